// File: rtl/beta_band_power.sv
// -----------------------------------------------------------------------------
// beta_band_power
//
// Windowed mean-square power estimator for the beta-band (14-32 Hz) filter
// output. Each valid signed sample is squared, the squares are summed over a
// window of WINDOW valid samples, and at the end of every window the mean
// (sum >> LOG2_WINDOW) is published together with a strict "above threshold"
// flag.
//
// Parameters
//   WINDOW       samples per window, power of two, 2..65536
//   LOG2_WINDOW  log2(WINDOW), must agree with WINDOW
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   reset      asynchronous, active-low; clears all state while low
//   x          signed 32-bit filtered sample
//   in_valid   x carries a new sample this cycle
//   clr        synchronous window restart (partial window discarded,
//              a close in the same cycle is cancelled, power/above hold)
//   thresh     unsigned 64-bit threshold, sampled at the window close edge
//   power      unsigned mean of x^2 over the last completed window
//   out_valid  one-cycle strobe: power/above were just updated
//   above      power > thresh for the last completed window
//
// Pipeline
//   stage 1: sq_r <= x*x           (one cycle after the sample edge)
//   stage 2: acc_r/cnt_r update, on the last sample of a window the mean is
//            registered straight into power/above with out_valid
// -----------------------------------------------------------------------------
module beta_band_power #(
    parameter int unsigned WINDOW      = 256,
    parameter int unsigned LOG2_WINDOW = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [31:0] x,
    input  logic               in_valid,
    input  logic               clr,
    input  logic        [63:0] thresh,
    output logic        [63:0] power,
    output logic               out_valid,
    output logic               above
);

    // Accumulator carries LOG2_WINDOW guard bits so a full window of 2^62
    // squares can never wrap.
    localparam int unsigned ACC_W = 64 + LOG2_WINDOW;

    localparam logic [LOG2_WINDOW-1:0] CNT_LAST = LOG2_WINDOW'(WINDOW - 1);
    localparam logic [LOG2_WINDOW-1:0] CNT_ONE  = LOG2_WINDOW'(1);

    // Stage 1 registers
    logic        [63:0]       sq_r;
    logic                     sq_v_r;

    // Stage 2 registers
    logic        [ACC_W-1:0]  acc_r;
    logic [LOG2_WINDOW-1:0]   cnt_r;

    // Combinational helpers
    logic signed [63:0]       x_ext_s;
    logic        [63:0]       sq_s;
    logic        [ACC_W-1:0]  sum_s;
    logic        [63:0]       mean_s;
    logic                     close_s;
    logic                     above_s;

    // Square, running sum, window mean and close/threshold decisions.
    always_comb begin
        x_ext_s = {{32{x[31]}}, x};
        // (-2^31)^2 = 2^62 is the largest square and fits the signed product.
        sq_s    = $unsigned(x_ext_s * x_ext_s);
        sum_s   = acc_r + {{LOG2_WINDOW{1'b0}}, sq_r};
        // Dropping the low LOG2_WINDOW bits is the truncating divide; the
        // remaining 64 bits always hold the full mean.
        mean_s  = sum_s[ACC_W-1:LOG2_WINDOW];
        if (sq_v_r && (cnt_r == CNT_LAST)) begin
            close_s = 1'b1;
        end else begin
            close_s = 1'b0;
        end
        if (mean_s > thresh) begin
            above_s = 1'b1;
        end else begin
            above_s = 1'b0;
        end
    end

    // Stage 1: register the square of each accepted sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sq_r   <= 64'd0;
            sq_v_r <= 1'b0;
        end else if (clr) begin
            // Sample presented together with clr is dropped.
            sq_v_r <= 1'b0;
        end else if (in_valid) begin
            sq_r   <= sq_s;
            sq_v_r <= 1'b1;
        end else begin
            sq_v_r <= 1'b0;
        end
    end

    // Stage 2: accumulate squares and count valid samples in the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
            cnt_r <= '0;
        end else if (close_s) begin
            // Next window begins with the very next valid square.
            acc_r <= '0;
            cnt_r <= '0;
        end else if (sq_v_r) begin
            acc_r <= sum_s;
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

    // Result registers: publish mean and threshold flag on window close.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            power     <= 64'd0;
            above     <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            // A close coinciding with clr is cancelled; last result holds.
            out_valid <= 1'b0;
        end else if (close_s) begin
            power     <= mean_s;
            above     <= above_s;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_beta_band_power.sv
// -----------------------------------------------------------------------------
// tb_beta_band_power
//
// Directed bench for beta_band_power with WINDOW=4. Inputs change on the
// falling edge (like the upstream filter); a monitor samples the outputs 1 ns
// after each rising edge and logs every out_valid strobe. All expected values
// are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_beta_band_power;

    localparam int unsigned WINDOW      = 4;
    localparam int unsigned LOG2_WINDOW = 2;

    localparam logic [63:0] P2_62 = 64'h4000_0000_0000_0000;

    logic               clk;
    logic               reset;
    logic signed [31:0] x;
    logic               in_valid;
    logic               clr;
    logic        [63:0] thresh;
    logic        [63:0] power;
    logic               out_valid;
    logic               above;

    int tests_run;
    int tests_failed;

    // Strobe log filled by the monitor
    int          cyc;
    int          strobe_cnt;
    logic [63:0] strobe_pow [$];
    int          strobe_cyc [$];

    int base;

    beta_band_power #(
        .WINDOW      (WINDOW),
        .LOG2_WINDOW (LOG2_WINDOW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .in_valid  (in_valid),
        .clr       (clr),
        .thresh    (thresh),
        .power     (power),
        .out_valid (out_valid),
        .above     (above)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: log each out_valid strobe, sampled away from the rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (out_valid === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_pow.push_back(power);
            strobe_cyc.push_back(cyc);
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), return at the
    // next falling edge, i.e. after exactly one rising edge.
    task automatic step(input logic v, input logic signed [31:0] xv, input logic c);
        in_valid = v;
        x        = xv;
        clr      = c;
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        strobe_cnt   = 0;
        reset        = 1'b0;
        x            = 32'sd0;
        in_valid     = 1'b0;
        clr          = 1'b0;
        thresh       = 64'd0;

        // ---------------- reset state ----------------
        @(negedge clk);
        @(negedge clk);
        check_val("reset_power", power, 64'd0);
        check_val("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("reset_above", {63'd0, above}, 64'd0);
        reset = 1'b1;
        step(1'b0, 32'sd0, 1'b0);

        // ---------------- 4 x 1000, latency ----------------
        thresh = 64'd999999;
        base   = strobe_cnt;
        for (int i = 0; i < 4; i++) step(1'b1, 32'sd1000, 1'b0);
        check_val("lat_edge_k_no_strobe", {63'd0, out_valid}, 64'd0);
        step(1'b0, 32'sd0, 1'b0);
        check_val("lat_edge_k1_strobe", {63'd0, out_valid}, 64'd1);
        check_val("p1000_power", power, 64'd1000000);
        check_val("p1000_above", {63'd0, above}, 64'd1);
        step(1'b0, 32'sd0, 1'b0);
        check_val("p1000_strobe_one_cycle", {63'd0, out_valid}, 64'd0);
        check_val("p1000_power_hold", power, 64'd1000000);
        check_val("p1000_strobe_count", 64'(strobe_cnt - base), 64'd1);

        // ---------------- most negative sample ----------------
        thresh = 64'd0;
        for (int i = 0; i < 4; i++) step(1'b1, 32'sh8000_0000, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        check_val("min_power", power, P2_62);
        check_val("min_above_thr0", {63'd0, above}, 64'd1);
        thresh = P2_62;
        for (int i = 0; i < 4; i++) step(1'b1, 32'sh8000_0000, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        check_val("min_power_rep", power, P2_62);
        check_val("min_above_strict", {63'd0, above}, 64'd0);
        // threshold change between closes has no effect
        thresh = 64'd0;
        step(1'b0, 32'sd0, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        check_val("thresh_not_resampled", {63'd0, above}, 64'd0);

        // ---------------- gapped samples 3,-3,5,-5 ----------------
        thresh = 64'd17;
        base   = strobe_cnt;
        step(1'b1, 32'sd3, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        step(1'b1, -32'sd3, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        step(1'b1, 32'sd5, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        check_val("gap_no_early_strobe", 64'(strobe_cnt - base), 64'd0);
        step(1'b1, -32'sd5, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        check_val("gap_strobe_count", 64'(strobe_cnt - base), 64'd1);
        check_val("gap_power", power, 64'd17);
        check_val("gap_above_equal", {63'd0, above}, 64'd0);

        // ---------------- back-to-back windows ----------------
        thresh = 64'd10;
        base   = strobe_cnt;
        for (int i = 0; i < 4; i++) step(1'b1, 32'sd2, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 32'sd4, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        check_val("b2b_strobe_count", 64'(strobe_cnt - base), 64'd2);
        if (strobe_cnt - base == 2) begin
            check_val("b2b_power_first", strobe_pow[base], 64'd4);
            check_val("b2b_power_second", strobe_pow[base + 1], 64'd16);
            check_val("b2b_spacing", 64'(strobe_cyc[base + 1] - strobe_cyc[base]), 64'd4);
        end
        check_val("b2b_above", {63'd0, above}, 64'd1);

        // ---------------- clr mid-window ----------------
        thresh = 64'd0;
        base   = strobe_cnt;
        step(1'b1, 32'sd10, 1'b0);
        step(1'b1, 32'sd10, 1'b0);
        step(1'b1, 32'sd10, 1'b1);
        check_val("clr_power_hold", power, 64'd16);
        for (int i = 0; i < 4; i++) step(1'b1, 32'sd1, 1'b0);
        check_val("clr_no_strobe_for_10s", 64'(strobe_cnt - base), 64'd0);
        step(1'b0, 32'sd0, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        check_val("clr_strobe_count", 64'(strobe_cnt - base), 64'd1);
        check_val("clr_power", power, 64'd1);
        check_val("clr_above", {63'd0, above}, 64'd1);

        // ---------------- async reset mid-window ----------------
        step(1'b1, 32'sd7, 1'b0);
        step(1'b1, 32'sd7, 1'b0);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_val("areset_power", power, 64'd0);
        check_val("areset_above", {63'd0, above}, 64'd0);
        check_val("areset_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        base  = strobe_cnt;
        for (int i = 0; i < 4; i++) step(1'b1, 32'sd7, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        step(1'b0, 32'sd0, 1'b0);
        check_val("areset_strobe_count", 64'(strobe_cnt - base), 64'd1);
        check_val("areset_power_49", power, 64'd49);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
